// File: rtl/level_fifo_pkg.sv
// Shared width helpers and default threshold constants for level_fifo.
// Imported by level_fifo and level_fifo_ram.
package level_fifo_pkg;

    // The default almost-full threshold sits this many words below DEPTH.
    localparam int unsigned AFULL_MARGIN   = 4;
    localparam int unsigned AEMPTY_DEFAULT = 4;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can hold the value DEPTH itself.
    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/level_fifo_ram.sv
// Simple dual-port storage for level_fifo.
// Synchronous write port and a registered read port, shaped for block-RAM inference.
module level_fifo_ram
    import level_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [ptr_width(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_en,
    input  logic [ptr_width(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]            rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The output register carries a synchronous reset; the array itself is never cleared.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/level_fifo.sv
// Synchronous FIFO with a registered level count, threshold flags and sticky error flags.
// Define LEVEL_FIFO_FWFT_EN to build the first-word-fall-through variant.
module level_fifo
    import level_fifo_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned AFULL_LEVEL  = DEPTH - AFULL_MARGIN,
    parameter int unsigned AEMPTY_LEVEL = AEMPTY_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_shift,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_full,
    output logic                        in_afull,
    input  logic                        out_pop,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_nempty,
    output logic                        out_aempty,
    output logic [lvl_width(DEPTH)-1:0] level,
    output logic                        overflow,
    output logic                        underflow,
    input  logic                        err_clear
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned LW = lvl_width(DEPTH);

    localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_LVL  = LW'(AFULL_LEVEL);
    localparam logic [LW-1:0] AEMPTY_LVL = LW'(AEMPTY_LEVEL);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_depth_check
        $error("level_fifo: DEPTH must be a power of two and at least 4");
    end

    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [PW-1:0]    rptr_d;
    logic [LW-1:0]    level_d;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] ram_data;
    logic             ram_rd_en;
    logic [PW-1:0]    ram_rd_addr;

    // Acceptance uses only registered flags, so a full FIFO still pops and an empty one still pushes.
    assign push = in_shift && !in_full;
    assign pop  = out_pop && out_nempty;

    always_comb begin
        rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
        level_d = level;
        case ({push, pop})
            2'b10:   level_d = level + LW'(1);
            2'b01:   level_d = level - LW'(1);
            default: level_d = level;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level      <= '0;
            in_full    <= 1'b0;
            in_afull   <= 1'b0;
            out_nempty <= 1'b0;
            out_aempty <= 1'b1;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            rptr_q     <= rptr_d;
            level      <= level_d;
            in_full    <= (level_d == FULL_LVL);
            in_afull   <= (level_d >= AFULL_LVL);
            out_nempty <= (level_d != '0);
            out_aempty <= (level_d <= AEMPTY_LVL);
            // A new error event takes priority over a simultaneous clear.
            overflow   <= (in_shift && in_full) || (overflow && !err_clear);
            underflow  <= (out_pop && !out_nempty) || (underflow && !err_clear);
        end
    end

`ifdef LEVEL_FIFO_FWFT_EN
    logic             bypass_q;
    logic [WIDTH-1:0] bypass_data_q;

    // Prefetch the word that will be at the head after this edge.
    assign ram_rd_en   = 1'b1;
    assign ram_rd_addr = rptr_d;

    // A word written into the slot being prefetched is not visible through the RAM yet.
    always_ff @(posedge clock) begin
        if (reset) begin
            bypass_q      <= 1'b0;
            bypass_data_q <= '0;
        end else begin
            bypass_q <= push && (wptr_q == rptr_d);
            if (push) begin
                bypass_data_q <= in_data;
            end
        end
    end

    assign out_data = bypass_q ? bypass_data_q : ram_data;
`else
    assign ram_rd_en   = pop;
    assign ram_rd_addr = rptr_q;
    assign out_data    = ram_data;
`endif

    level_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (push),
        .wr_addr (wptr_q),
        .wr_data (in_data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_data)
    );

endmodule

// File: tb/tb_level_fifo.sv
// Self-checking bench for level_fifo (DEPTH=8): directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_level_fifo;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 8;
    localparam int AFULL  = DEPTH - 4;
    localparam int AEMPTY = 4;

    logic             clock;
    logic             reset;
    logic             in_shift;
    logic [WIDTH-1:0] in_data;
    logic             in_full;
    logic             in_afull;
    logic             out_pop;
    logic [WIDTH-1:0] out_data;
    logic             out_nempty;
    logic             out_aempty;
    logic [3:0]       level;
    logic             overflow;
    logic             underflow;
    logic             err_clear;

    level_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_shift   (in_shift),
        .in_data    (in_data),
        .in_full    (in_full),
        .in_afull   (in_afull),
        .out_pop    (out_pop),
        .out_data   (out_data),
        .out_nempty (out_nempty),
        .out_aempty (out_aempty),
        .level      (level),
        .overflow   (overflow),
        .underflow  (underflow),
        .err_clear  (err_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests  = 0;
    int failed = 0;

    // Reference model: stored words, last popped word, sticky flags.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_out = '0;
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;

    typedef struct {
        bit               rst;
        bit               sh;
        logic [WIDTH-1:0] d;
        bit               pp;
        bit               clr;
        int               lvl;
        bit               full;
        bit               ne;
        bit               ovf;
        bit               unf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        n = mq.size();
        chk("level", 32'(level), 32'(n));
        chk("in_full", 32'(in_full), 32'(n == DEPTH));
        chk("in_afull", 32'(in_afull), 32'(n >= AFULL));
        chk("out_aempty", 32'(out_aempty), 32'(n <= AEMPTY));
        chk("out_nempty", 32'(out_nempty), 32'(n > 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef LEVEL_FIFO_FWFT_EN
        if (n > 0) chk("out_data_head", 32'(out_data), 32'(mq[0]));
`else
        chk("out_data", 32'(out_data), 32'(m_out));
`endif
    endtask

    // Drive one clock of inputs, advance the model by the same rules, then compare.
    task automatic cycle(input bit rst, input bit sh, input logic [WIDTH-1:0] d,
                         input bit pp, input bit clr);
        bit               acc_push;
        bit               acc_pop;
        int               n;
        logic [WIDTH-1:0] w;
        reset     = rst;
        in_shift  = sh;
        in_data   = d;
        out_pop   = pp;
        err_clear = clr;
        @(posedge clock);
        #1;
        if (rst) begin
            mq.delete();
            m_out = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            n        = mq.size();
            acc_push = sh && (n < DEPTH);
            acc_pop  = pp && (n > 0);
            m_ovf    = (sh && !acc_push) || (m_ovf && !clr);
            m_unf    = (pp && !acc_pop) || (m_unf && !clr);
            if (acc_pop) begin
                w = mq.pop_front();
`ifndef LEVEL_FIFO_FWFT_EN
                m_out = w;
`endif
            end
            if (acc_push) mq.push_back(d);
        end
        check_model();
    endtask

    function automatic void add(bit rst, bit sh, logic [WIDTH-1:0] d, bit pp, bit clr,
                                int lvl, bit full, bit ne, bit ovf, bit unf);
        vec_t v;
        v.rst = rst; v.sh = sh; v.d = d; v.pp = pp; v.clr = clr;
        v.lvl = lvl; v.full = full; v.ne = ne; v.ovf = ovf; v.unf = unf;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [WIDTH-1:0] rd;
        reset     = 1'b1;
        in_shift  = 1'b0;
        in_data   = '0;
        out_pop   = 1'b0;
        err_clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // rst sh d pp clr | lvl full ne ovf unf
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) add(0, 1, 8'(i), 0, 0, i, 0, 1, 0, 0);
        for (int i = 3; i >= 0; i--) add(0, 0, 8'h00, 1, 0, i, 0, i > 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 8'(8'h10 + i), 0, 0, i, i == 8, 1, 0, 0);
        add(0, 1, 8'h19, 0, 1, 8, 1, 1, 1, 0);
        add(0, 0, 8'h00, 0, 1, 8, 1, 1, 0, 0);
        add(0, 1, 8'h1a, 0, 0, 8, 1, 1, 1, 0);
        add(0, 0, 8'h00, 0, 1, 8, 1, 1, 0, 0);
        add(0, 1, 8'h20, 1, 0, 7, 0, 1, 1, 0);
        add(0, 0, 8'h00, 1, 0, 6, 0, 1, 1, 0);
        add(0, 0, 8'h00, 1, 0, 5, 0, 1, 1, 0);
        add(1, 1, 8'h30, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].sh, tbl[i].d, tbl[i].pp, tbl[i].clr);
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_full", i), 32'(in_full), 32'(tbl[i].full));
            chk($sformatf("tbl%0d_nempty", i), 32'(out_nempty), 32'(tbl[i].ne));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_unf", i), 32'(underflow), 32'(tbl[i].unf));
        end

        // Single word read latency / fall-through.
        cycle(1, 0, 8'h00, 0, 0);
        cycle(0, 1, 8'hA5, 0, 0);
`ifdef LEVEL_FIFO_FWFT_EN
        chk("fwft_nempty", 32'(out_nempty), 32'd1);
        chk("fwft_data", 32'(out_data), 32'hA5);
`else
        chk("nofwft_data_before_pop", 32'(out_data), 32'h00);
        cycle(0, 0, 8'h00, 1, 0);
        chk("nofwft_data_after_pop", 32'(out_data), 32'hA5);
`endif
        // Underflow must not disturb out_data.
        cycle(1, 0, 8'h00, 0, 0);
        cycle(0, 1, 8'h5C, 0, 0);
        cycle(0, 0, 8'h00, 1, 0);
        rd = out_data;
        cycle(0, 0, 8'h00, 1, 0);
        chk("underflow_set", 32'(underflow), 32'd1);
`ifndef LEVEL_FIFO_FWFT_EN
        chk("underflow_data_hold", 32'(out_data), 32'(rd));
`endif

        // Steady streaming at level 4 wraps both pointers several times.
        cycle(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 8'($urandom), 0, 0);
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, 8'($urandom), 1, 0);
            chk("stream_level", 32'(level), 32'd4);
        end

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 55, 8'($urandom),
                  $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/level_fifo.md
LEVEL_FIFO -- requirements
Module: level_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 256, capacity in words; power of two, >=4.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-4, almost-full threshold in words.
REQ-004 SHALL have parameter AEMPTY_LEVEL, default 4, almost-empty threshold in words.
REQ-005 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port in_shift  in  1  push request.
REQ-008 SHALL have port in_data  in  WIDTH  push data.
REQ-009 SHALL have port in_full  out  1  registered; level == DEPTH.
REQ-010 SHALL have port in_afull  out  1  registered; level >= AFULL_LEVEL.
REQ-011 SHALL have port out_pop  in  1  pop request.
REQ-012 SHALL have port out_data  out  WIDTH  registered read data.
REQ-013 SHALL have port out_nempty  out  1  registered; a word is poppable.
REQ-014 SHALL have port out_aempty  out  1  registered; level <= AEMPTY_LEVEL.
REQ-015 SHALL have port level  out  $clog2(DEPTH)+1  registered word count, 0..DEPTH.
REQ-016 SHALL have port overflow  out  1  sticky; a push was rejected.
REQ-017 SHALL have port underflow  out  1  sticky; a pop was rejected.
REQ-018 SHALL have port err_clear  in  1  clears overflow and underflow.

Function
REQ-019 Push SHALL be accepted iff in_shift && !in_full; pop SHALL be accepted iff out_pop && out_nempty; both are evaluated on pre-edge register values.
REQ-020 All DEPTH entries SHALL be usable; the write and read pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 level SHALL update by +1 on push only, -1 on pop only, and stay unchanged on simultaneous accepted push and pop.
REQ-022 in_full, in_afull, out_aempty and out_nempty SHALL be registered from the next-cycle level, so they are exact in the cycle after each edge with no lag.
REQ-023 When full with in_shift and out_pop both high, the pop SHALL be accepted, the push rejected, and overflow set.
REQ-024 When empty with in_shift and out_pop both high, the push SHALL be accepted, the pop rejected, and underflow set.
REQ-025 A rejected push SHALL leave memory, pointers and level unchanged.
REQ-026 overflow and underflow SHALL hold once set until err_clear or reset; a set event in the same cycle as err_clear SHALL win.
REQ-027 Without FWFT, out_data SHALL load memory[read pointer] on the edge of an accepted pop (1-cycle read latency) and SHALL otherwise hold its value.

Reset
REQ-028 While reset is high at an edge: pointers 0, level 0, in_full 0, in_afull 0, out_nempty 0, out_aempty 1, overflow 0, underflow 0, out_data 0.
REQ-029 Reset SHALL override any push or pop in the same cycle; memory contents need not be cleared.
REQ-030 Reset asserted mid-operation SHALL discard all stored words.

Configuration
REQ-031 Macro LEVEL_FIFO_FWFT_EN SHALL select first-word-fall-through mode.
REQ-032 With LEVEL_FIFO_FWFT_EN: out_data SHALL present the head word whenever out_nempty=1, and an accepted pop SHALL advance to the next word on the same edge.
REQ-033 With LEVEL_FIFO_FWFT_EN: a push into an empty FIFO SHALL make out_nempty=1 with out_data=in_data one cycle later.
REQ-034 With LEVEL_FIFO_FWFT_EN: level SHALL count the head word.
REQ-035 Without LEVEL_FIFO_FWFT_EN, REQ-027 applies.

Structure
REQ-036 Package level_fifo_pkg SHALL hold the pointer/level width function and the default threshold constants.
REQ-037 Storage SHALL be a sub-module level_fifo_ram: simple dual-port, one synchronous write port and one registered read port, inferable as block RAM.

Verification
REQ-038 Reset, then push 0x01..0x04 with pops idle -> level=4, out_aempty=1; then 4 pops -> out_data 0x01..0x04 in order (one cycle late when non-FWFT), out_nempty=0 after the 4th pop.
REQ-039 DEPTH=8: push 8 words -> in_full=1, level=8; a 9th push -> overflow=1, level=8; err_clear -> overflow=0.
REQ-040 DEPTH=8, full: in_shift=1 and out_pop=1 for one cycle -> pop accepted, level=7, overflow=1.
REQ-041 DEPTH=8: push and pop streaming for 40 cycles -> pointers wrap, data matches a reference model, level stays constant.
REQ-042 Pop when empty -> underflow=1, out_data unchanged; reset asserted with level=5 -> next cycle level=0, out_nempty=0.
REQ-043 FWFT build: single push of 0xA5 into empty FIFO -> next cycle out_nempty=1, out_data=0xA5 before any pop.
